keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 113 +++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-strobing matrix keypad scanner with settle, press/release debounce and a ready/ack handshake.
module keypad_scanner #(
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_COLS-1:0] cols,
    input  logic                ack,
    output logic [NUM_ROWS-1:0] rows,
    output logic                dataReady,
    output logic [31:0]         foundRow,
    output logic [31:0]         foundCol,
    output logic                busy
);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int CW = $clog2(NUM_COLS);
    localparam int MAXC = SETTLE_CYCLES > DEBOUNCE_CYCLES ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int NW = $clog2(MAXC + 1);
    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, DEBOUNCE, READY, RELEASE} state_t;
    state_t state, state_n;
    logic [RW-1:0] idx, idx_n, idx_inc;
    logic [CW-1:0] col, col_n, low;
    logic [NW-1:0] cnt, cnt_n;
    logic [NUM_ROWS-1:0] rows_n;
    logic [31:0] row_q_n, col_q_n;
    logic any_low, hit, ready_n;
    assign idx_inc = idx == RW'(NUM_ROWS - 1) ? '0 : idx + 1'b1;
    assign hit = cols[col];
    // descending walk so the lowest closed column is the one left standing
    always_comb begin
        low = '0;
        any_low = 1'b0;
        for (int i = NUM_COLS - 1; i >= 0; i--)
            if (!cols[i]) begin
                low = CW'(i);
                any_low = 1'b1;
            end
    end
    always_comb begin
        state_n = state;
        idx_n = idx;
        col_n = col;
        cnt_n = cnt;
        ready_n = dataReady;
        row_q_n = foundRow;
        col_q_n = foundCol;
        case (state)
            IDLE: if (start) begin
                state_n = SETTLE;
                idx_n = '0;
                cnt_n = '0;
            end
            SETTLE: begin
                cnt_n = cnt == NW'(SETTLE_CYCLES - 1) ? '0 : cnt + 1'b1;
                state_n = cnt == NW'(SETTLE_CYCLES - 1) ? SAMPLE : SETTLE;
            end
            SAMPLE: begin
                state_n = any_low ? DEBOUNCE : SETTLE;
                col_n = any_low ? low : col;
                idx_n = any_low ? idx : idx_inc;
                cnt_n = '0;
            end
            DEBOUNCE: if (hit) begin
                state_n = SETTLE;
                idx_n = idx_inc;
                cnt_n = '0;
            end else if (cnt == NW'(DEBOUNCE_CYCLES - 1)) begin
                state_n = READY;
                ready_n = 1'b1;
                row_q_n = 32'(idx);
                col_q_n = 32'(col);
                cnt_n = '0;
            end else cnt_n = cnt + 1'b1;
            READY: if (ack) begin
                state_n = RELEASE;
                ready_n = 1'b0;
            end
            RELEASE: begin
                cnt_n = !hit || cnt == NW'(DEBOUNCE_CYCLES - 1) ? '0 : cnt + 1'b1;
                state_n = hit && cnt == NW'(DEBOUNCE_CYCLES - 1) ? IDLE : RELEASE;
            end
            default: state_n = IDLE;
        endcase
        rows_n = '1;
        if (state_n != IDLE) rows_n[idx_n] = 1'b0;
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            col <= '0;
            cnt <= '0;
            rows <= '1;
            dataReady <= 1'b0;
            foundRow <= '0;
            foundCol <= '0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            col <= col_n;
            cnt <= cnt_n;
            rows <= rows_n;
            dataReady <= ready_n;
            foundRow <= row_q_n;
            foundCol <= col_q_n;
            busy <= state_n != IDLE;
        end
endmodule
